// File: rtl/modport_mem.sv
//------------------------------------------------------------------------------
// modport_mem
//
// Scratch memory of DEPTH x DATA_W words behind the memory bus interface.
// Writes are committed synchronously on the rising edge of clk. Reads are
// asynchronous: while a read is in progress, data_out follows mem[addr]. When
// no read is in progress, data_out shows the last value read (rd_q).
//
// The asynchronous active-low reset clears every word, clears rd_q, and forces
// data_out to zero.
//
// Optional feature (compile-time macro MEM_BYPASS_EN):
//   When read and write are both high, data_out forwards data_in and rd_q
//   captures data_in. The write to mem[addr] is still performed.
//   When the macro is undefined, the write wins and data_out holds rd_q.
//
// Parameters:
//   ADDR_W  address width
//   DATA_W  word width
//   DEPTH   number of words; must equal 2**ADDR_W
//
// Ports:
//   clk       in   clock; all state changes on the rising edge
//   rst_n     in   asynchronous active-low reset
//   addr      in   [ADDR_W-1:0] word address for read and write
//   data_in   in   [DATA_W-1:0] write data
//   read      in   read enable (level-sensitive)
//   write     in   write enable (level-sensitive)
//   data_out  out  [DATA_W-1:0] read data
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module modport_mem #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] rd_q;

    // A plain read only happens when no write is in progress.
    // A write always takes priority over a read to the array.
    logic rd_en;
    logic wr_en;
    logic fwd_en;

    assign rd_en = read & ~write;
    assign wr_en = write;

`ifdef MEM_BYPASS_EN
    // A simultaneous read and write returns the data being written.
    assign fwd_en = read & write;
`else
    assign fwd_en = 1'b0;
`endif

    // Storage array. The reset clears every word so that a write in flight
    // when reset arrives is lost, and the word reads back as zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[addr] <= data_in;
        end
    end

    // Read-hold register: it keeps the most recent read result so that
    // data_out is stable after read falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if (fwd_en) begin
            rd_q <= data_in;
        end else if (rd_en) begin
            rd_q <= mem[addr];
        end
    end

    // Output mux. rst_n is included explicitly so that data_out is zero during
    // reset even in the forwarding path, where data_in would otherwise leak
    // through.
    always_comb begin
        data_out = rd_q;
        if (!rst_n) begin
            data_out = '0;
        end else if (fwd_en) begin
            data_out = data_in;
        end else if (rd_en) begin
            data_out = mem[addr];
        end
    end

endmodule

// File: tb/tb_modport_mem.sv
`timescale 1ns/1ps

module tb_modport_mem;

    logic       clk;
    logic       rst_n;
    logic [4:0] addr;
    logic [7:0] data_in;
    logic       read;
    logic       write;
    logic [7:0] data_out;

    int tests;
    int fails;

    modport_mem #(.ADDR_W(5), .DATA_W(8), .DEPTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .data_in  (data_in),
        .read     (read),
        .write    (write),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] exp);
        tests++;
        assert (data_out === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, data_out, exp);
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        addr    = a;
        data_in = d;
        write   = 1'b1;
        read    = 1'b0;
        @(negedge clk);
        write   = 1'b0;
    endtask

    // Drives a read on the falling edge. It checks the combinational value
    // mid-cycle, and checks again just after the rising edge. read is left high.
    task automatic do_read(input logic [4:0] a, input logic [7:0] exp, input string tag);
        @(negedge clk);
        addr  = a;
        read  = 1'b1;
        write = 1'b0;
        #2 check(tag, exp);
        @(posedge clk);
        #1 check({tag, "_post"}, exp);
    endtask

    logic [7:0] simul_exp;

    initial begin
        tests   = 0;
        fails   = 0;
        addr    = '0;
        data_in = '0;
        read    = 1'b0;
        write   = 1'b0;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;
        #3 check("reset_out", 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset then read
        do_read(5'd0,  8'h00, "rst_rd0");
        do_read(5'd17, 8'h00, "rst_rd17");
        do_read(5'd31, 8'h00, "rst_rd31");

        // Write then read
        do_write(5'd3,  8'hA5);
        do_write(5'd31, 8'h3C);
        do_read(5'd3,  8'hA5, "wr_rd3");
        do_read(5'd31, 8'h3C, "wr_rd31");

        // Overwrite and hold
        do_write(5'd7, 8'h11);
        do_write(5'd7, 8'h22);
        do_read(5'd7, 8'h22, "ovr_rd7");
        @(negedge clk);
        read = 1'b0;
        addr = 5'd0;
        #2 check("hold_mid", 8'h22);
        @(posedge clk);
        #1 check("hold_post", 8'h22);
        @(posedge clk);
        #1 check("hold_2cyc", 8'h22);

        // Full sweep
        for (int i = 0; i < 32; i++) begin
            do_write(5'(i), 8'(i) ^ 8'h5A);
        end
        for (int i = 0; i < 32; i++) begin
            do_read(5'(i), 8'(i) ^ 8'h5A, $sformatf("sweep%0d", i));
        end

        // Back-to-back write then read of the same address
        do_write(5'd12, 8'h77);
        do_read(5'd12, 8'h77, "b2b_rd12");

        // Simultaneous read and write
        do_write(5'd9, 8'h01);
        do_read(5'd9, 8'h01, "sim_pre");
`ifdef MEM_BYPASS_EN
        simul_exp = 8'hFF;
`else
        simul_exp = 8'h01;
`endif
        @(negedge clk);
        addr    = 5'd9;
        data_in = 8'hFF;
        read    = 1'b1;
        write   = 1'b1;
        #2 check("sim_mid", simul_exp);
        @(posedge clk);
        #1 check("sim_post", simul_exp);
        @(negedge clk);
        read  = 1'b0;
        write = 1'b0;
        #2 check("sim_hold", simul_exp);
        do_read(5'd9, 8'hFF, "sim_rd9");

        // Async reset mid-read
        do_write(5'd3, 8'hA5);
        @(negedge clk);
        addr  = 5'd3;
        read  = 1'b1;
        write = 1'b0;
        #2 check("rrd_before", 8'hA5);
        #1 rst_n = 1'b0;
        #1 check("rrd_async", 8'h00);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("rrd_after", 8'h00);
        do_read(5'd3,  8'h00, "rrd_rd3");
        do_read(5'd31, 8'h00, "rrd_rd31");

        // Reset asserted mid-write: the write is lost
        @(negedge clk);
        addr    = 5'd5;
        data_in = 8'h99;
        read    = 1'b0;
        write   = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        write = 1'b0;
        do_read(5'd5, 8'h00, "rwr_rd5");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Cycle budget guard
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish required finish");
        $fatal(1, "timeout");
    end

endmodule
